// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read at a time
// and registers the returned word into the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc,
  output logic        ID_valid,
  output logic [1:0]  fetch_state
);

  // Handshake: a request transfers when im_req && im_gnt; exactly one im_rvalid
  // follows each transfer, no earlier than the next cycle.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        kill, kill_n;
  logic [31:0] buf_inst, buf_inst_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] id_inst_q, id_inst_n;
  logic [31:0] id_pc_q, id_pc_n;
  logic        id_valid_q, id_valid_n;
  logic        id_free;

  assign id_free     = !id_valid_q || !id_stall;
  assign im_req      = (state == S_REQ);
  assign im_addr     = pc;
  assign ID_inst     = id_inst_q;
  assign ID_pc       = id_pc_q;
  assign ID_valid    = id_valid_q;
  assign fetch_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      buf_inst   <= 32'h0;
      buf_pc     <= 32'h0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= 32'h0;
      id_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      kill       <= kill_n;
      buf_inst   <= buf_inst_n;
      buf_pc     <= buf_pc_n;
      id_inst_q  <= id_inst_n;
      id_pc_q    <= id_pc_n;
      id_valid_q <= id_valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    kill_n     = kill;
    buf_inst_n = buf_inst;
    buf_pc_n   = buf_pc;
    id_inst_n  = id_inst_q;
    id_pc_n    = id_pc_q;
    id_valid_n = id_valid_q;

    // Consumed by ID; a load below overrides this
    if (id_valid_q && !id_stall) begin
      id_valid_n = 1'b0;
      id_inst_n  = NOP_INST;
    end

    if (ex_redirect) begin
      id_valid_n = 1'b0;
      id_inst_n  = NOP_INST;
      pc_n       = ex_target & 32'hFFFF_FFFC;
      kill_n     = 1'b0;
      unique case (state)
        S_REQ: begin
          if (im_gnt) begin
            state_n = S_WAIT;
            kill_n  = 1'b1;
          end
        end
        S_WAIT: begin
          // A response still in flight belongs to the old path
          if (im_rvalid) state_n = S_REQ;
          else           kill_n  = 1'b1;
        end
        default: state_n = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (im_gnt) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (im_rvalid) begin
            if (kill) begin
              kill_n  = 1'b0;
              state_n = S_REQ;
            end else if (id_free) begin
              id_inst_n  = im_rdata;
              id_pc_n    = pc;
              id_valid_n = 1'b1;
              pc_n       = pc + 32'd4;
              state_n    = S_REQ;
            end else begin
              buf_inst_n = im_rdata;
              buf_pc_n   = pc;
              state_n    = S_HOLD;
            end
          end
        end
        default: begin
          if (id_free) begin
            id_inst_n  = buf_inst;
            id_pc_n    = buf_pc;
            id_valid_n = 1'b1;
            pc_n       = pc + 32'd4;
            state_n    = S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: zero-wait memory model, stall, redirect,
// PC wrap (second instance) and mid-transaction reset.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        rst_w_n;
  logic        gnt_en;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_target;

  logic        im_req, im_gnt, im_rvalid;
  logic [31:0] im_addr, im_rdata;
  logic [31:0] ID_inst, ID_pc;
  logic        ID_valid;
  logic [1:0]  fetch_state;

  logic        w_req, w_gnt, w_rvalid;
  logic [31:0] w_addr, w_rdata;
  logic [31:0] w_inst, w_pc;
  logic        w_valid;
  logic [1:0]  w_state;
  logic        w_stall, w_redirect;
  logic [31:0] w_target;

  int vectors = 0;
  int errors  = 0;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .id_stall(id_stall), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ID_inst(ID_inst), .ID_pc(ID_pc), .ID_valid(ID_valid),
    .fetch_state(fetch_state)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_w_n),
    .im_req(w_req), .im_addr(w_addr), .im_gnt(w_gnt),
    .im_rvalid(w_rvalid), .im_rdata(w_rdata),
    .id_stall(w_stall), .ex_redirect(w_redirect), .ex_target(w_target),
    .ID_inst(w_inst), .ID_pc(w_pc), .ID_valid(w_valid),
    .fetch_state(w_state)
  );

  // Instruction memory contents shared by both memory models
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0010_0093;
      32'h0000_0004: mem_word = 32'h0020_0113;
      default:       mem_word = {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endcase
  endfunction

  assign im_gnt = gnt_en;
  assign w_gnt  = 1'b1;

  // Zero-wait memories: response the cycle after grant, reset with the fetch unit
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_rvalid <= 1'b0;
      im_rdata  <= 32'h0;
    end else begin
      im_rvalid <= im_req && im_gnt;
      im_rdata  <= mem_word(im_addr);
    end
  end

  always @(posedge clk or negedge rst_w_n) begin
    if (!rst_w_n) begin
      w_rvalid <= 1'b0;
      w_rdata  <= 32'h0;
    end else begin
      w_rvalid <= w_req && w_gnt;
      w_rdata  <= mem_word(w_addr);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_w_n = 1'b0; gnt_en = 1'b1; id_stall = 1'b0;
    ex_redirect = 1'b0; ex_target = 32'h0;
    w_stall = 1'b0; w_redirect = 1'b0; w_target = 32'h0;
    step(); step();
    vectors++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ID_valid); end
    vectors++; if (ID_inst !== NOP) begin errors++; $display("FAIL rst_inst: got %h want %h", ID_inst, NOP); end
    vectors++; if (ID_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", ID_pc); end
    vectors++; if (im_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %b want 1", im_req); end
    vectors++; if (im_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", im_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin errors++; $display("FAIL zw_req0: got %b/%h want 1/0", im_req, im_addr); end
    step();
    vectors++; if (im_req !== 1'b0 || ID_valid !== 1'b0) begin errors++; $display("FAIL zw_wait0: got req=%b valid=%b want 0/0", im_req, ID_valid); end
    step();
    vectors++; if (ID_valid !== 1'b1 || ID_inst !== 32'h0010_0093 || ID_pc !== 32'h0) begin errors++; $display("FAIL zw_id0: got %b %h %h want 1 00100093 0", ID_valid, ID_inst, ID_pc); end
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h4) begin errors++; $display("FAIL zw_req4: got %b/%h want 1/4", im_req, im_addr); end
    step();
    vectors++; if (ID_valid !== 1'b0 || ID_inst !== NOP) begin errors++; $display("FAIL zw_consumed: got %b %h want 0 %h", ID_valid, ID_inst, NOP); end
    step();
    vectors++; if (ID_valid !== 1'b1 || ID_inst !== 32'h0020_0113 || ID_pc !== 32'h4) begin errors++; $display("FAIL zw_id4: got %b %h %h want 1 00200113 4", ID_valid, ID_inst, ID_pc); end
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h8) begin errors++; $display("FAIL zw_req8: got %b/%h want 1/8", im_req, im_addr); end
  endtask

  task automatic test_stall();
    id_stall = 1'b1;
    step();
    vectors++; if (ID_valid !== 1'b1 || ID_inst !== 32'h0020_0113 || ID_pc !== 32'h4) begin errors++; $display("FAIL st_hold_wait: got %b %h %h want 1 00200113 4", ID_valid, ID_inst, ID_pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (im_req !== 1'b0 || fetch_state !== 2'd2) begin errors++; $display("FAIL st_noreq: got req=%b state=%0d want 0/2", im_req, fetch_state); end
      vectors++; if (ID_valid !== 1'b1 || ID_inst !== 32'h0020_0113 || ID_pc !== 32'h4) begin errors++; $display("FAIL st_stable: got %b %h %h want 1 00200113 4", ID_valid, ID_inst, ID_pc); end
    end
    id_stall = 1'b0;
    step();
    vectors++; if (ID_valid !== 1'b1 || ID_inst !== mem_word(32'h8) || ID_pc !== 32'h8) begin errors++; $display("FAIL st_release: got %b %h %h want 1 %h 8", ID_valid, ID_inst, ID_pc, mem_word(32'h8)); end
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'hC) begin errors++; $display("FAIL st_req: got %b/%h want 1/c", im_req, im_addr); end
  endtask

  task automatic test_redirect_grant();
    ex_redirect = 1'b1; ex_target = 32'h0000_0103;
    step();
    ex_redirect = 1'b0; ex_target = 32'h0;
    vectors++; if (ID_valid !== 1'b0 || ID_inst !== NOP) begin errors++; $display("FAIL rg_flush: got %b %h want 0 %h", ID_valid, ID_inst, NOP); end
    vectors++; if (im_req !== 1'b0) begin errors++; $display("FAIL rg_wait: got %b want 0", im_req); end
    step();
    vectors++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL rg_drop: got %b want 0", ID_valid); end
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h100) begin errors++; $display("FAIL rg_addr: got %b/%h want 1/100", im_req, im_addr); end
    step(); step();
    vectors++; if (ID_valid !== 1'b1 || ID_pc !== 32'h100 || ID_inst !== mem_word(32'h100)) begin errors++; $display("FAIL rg_id: got %b %h %h want 1 100 %h", ID_valid, ID_pc, ID_inst, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_nogrant();
    gnt_en = 1'b0; ex_redirect = 1'b1; ex_target = 32'h0000_0203;
    step();
    ex_redirect = 1'b0; ex_target = 32'h0;
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h200) begin errors++; $display("FAIL rn_addr: got %b/%h want 1/200", im_req, im_addr); end
    vectors++; if (ID_valid !== 1'b0) begin errors++; $display("FAIL rn_flush: got %b want 0", ID_valid); end
    gnt_en = 1'b1;
    step(); step();
    vectors++; if (ID_valid !== 1'b1 || ID_pc !== 32'h200 || ID_inst !== mem_word(32'h200)) begin errors++; $display("FAIL rn_id: got %b %h %h want 1 200 %h", ID_valid, ID_pc, ID_inst, mem_word(32'h200)); end
  endtask

  task automatic test_redirect_hold();
    id_stall = 1'b1;
    step(); step();
    vectors++; if (im_req !== 1'b0 || fetch_state !== 2'd2) begin errors++; $display("FAIL rh_hold: got req=%b state=%0d want 0/2", im_req, fetch_state); end
    ex_redirect = 1'b1; ex_target = 32'h0000_0300;
    step();
    ex_redirect = 1'b0; ex_target = 32'h0;
    vectors++; if (ID_valid !== 1'b0 || ID_inst !== NOP) begin errors++; $display("FAIL rh_flush: got %b %h want 0 %h", ID_valid, ID_inst, NOP); end
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h300) begin errors++; $display("FAIL rh_addr: got %b/%h want 1/300", im_req, im_addr); end
    id_stall = 1'b0;
    step(); step();
    vectors++; if (ID_valid !== 1'b1 || ID_pc !== 32'h300 || ID_inst !== mem_word(32'h300)) begin errors++; $display("FAIL rh_id: got %b %h %h want 1 300 %h", ID_valid, ID_pc, ID_inst, mem_word(32'h300)); end
  endtask

  task automatic test_reset_mid();
    id_stall = 1'b1;
    step();
    vectors++; if (im_req !== 1'b0 || ID_valid !== 1'b1) begin errors++; $display("FAIL rm_pre: got req=%b valid=%b want 0/1", im_req, ID_valid); end
    rst_n = 1'b0;
    #1;
    vectors++; if (ID_valid !== 1'b0 || ID_inst !== NOP) begin errors++; $display("FAIL rm_async: got %b %h want 0 %h", ID_valid, ID_inst, NOP); end
    id_stall = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %b/%h want 1/0", im_req, im_addr); end
    step(); step();
    vectors++; if (ID_valid !== 1'b1 || ID_inst !== 32'h0010_0093 || ID_pc !== 32'h0) begin errors++; $display("FAIL rm_id: got %b %h %h want 1 00100093 0", ID_valid, ID_inst, ID_pc); end
  endtask

  task automatic test_wrap();
    rst_w_n = 1'b0;
    step();
    rst_w_n = 1'b1;
    vectors++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr0: got %b/%h want 1/fffffffc", w_req, w_addr); end
    step(); step();
    vectors++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_inst !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wr_id0: got %b %h %h want 1 fffffffc %h", w_valid, w_pc, w_inst, mem_word(32'hFFFF_FFFC)); end
    vectors++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin errors++; $display("FAIL wr_addr1: got %b/%h want 1/0", w_req, w_addr); end
    step(); step();
    vectors++; if (w_valid !== 1'b1 || w_pc !== 32'h0 || w_inst !== 32'h0010_0093) begin errors++; $display("FAIL wr_id1: got %b %h %h want 1 0 00100093", w_valid, w_pc, w_inst); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_grant();
    test_redirect_nogrant();
    test_redirect_hold();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
